// File: rtl/serial_subtractor.sv
// Bit-serial 4-bit subtractor: one full-subtractor cell plus a registered borrow, d = {borrow, (a-b) mod 16}.
// Optional build macro SERIAL_SUB_SATURATE_EN clamps a borrowing result to zero.
module serial_subtractor (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [4:0] d
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] a_sh_q, a_sh_d;
    logic [3:0] b_sh_q, b_sh_d;
    logic [3:0] res_q, res_d;
    logic       br_q, br_d;
    logic [1:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [4:0] d_q, d_d;

    function automatic logic fs_diff(input logic ai, input logic bi, input logic bri);
        return ai ^ bi ^ bri;
    endfunction

    function automatic logic fs_borrow(input logic ai, input logic bi, input logic bri);
        return (~ai & bi) | (~(ai ^ bi) & bri);
    endfunction

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= 4'd0;
            b_sh_q  <= 4'd0;
            res_q   <= 4'd0;
            br_q    <= 1'b0;
            cnt_q   <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= 5'd0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            d_q     <= d_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_q == 2'd3) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output decode; busy/done lag the state by one register stage
    always_comb begin
        a_sh_d = a_sh_q;
        b_sh_d = b_sh_q;
        res_d  = res_q;
        br_d   = br_q;
        cnt_d  = cnt_q;
        d_d    = d_q;
        busy_d = (state_q == SHIFT);
        done_d = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d = a;
                    b_sh_d = b;
                    br_d   = 1'b0;
                    cnt_d  = 2'd0;
                end else begin
                    a_sh_d = a_sh_q;
                end
            end
            SHIFT: begin
                // LSB-first: each new difference bit enters at the top and ripples down
                res_d  = {fs_diff(a_sh_q[0], b_sh_q[0], br_q), res_q[3:1]};
                br_d   = fs_borrow(a_sh_q[0], b_sh_q[0], br_q);
                a_sh_d = {1'b0, a_sh_q[3:1]};
                b_sh_d = {1'b0, b_sh_q[3:1]};
                cnt_d  = cnt_q + 2'd1;
            end
            DONE: begin
`ifdef SERIAL_SUB_SATURATE_EN
                if (br_q) begin
                    d_d = 5'd0;
                end else begin
                    d_d = {br_q, res_q};
                end
`else
                d_d = {br_q, res_q};
`endif
            end
            default: begin
                d_d = d_q;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, handshake corner cases, exhaustive sweep.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [4:0] d;

    int compared   = 0;
    int mismatched = 0;
    int done_cnt   = 0;
    logic [4:0] exp_q[$];

    typedef struct {
        logic [3:0] va;
        logic [3:0] vb;
        logic [4:0] vexp;
    } vec_t;

    serial_subtractor dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .d     (d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [4:0] sat(input logic [4:0] full);
        logic [4:0] r;
        r = full;
`ifdef SERIAL_SUB_SATURATE_EN
        if (full[4]) r = 5'd0;
`endif
        return r;
    endfunction

    function automatic logic [4:0] model(input logic [3:0] aa, input logic [3:0] bb);
        return sat({1'b0, aa} - {1'b0, bb});
    endfunction

    // Scoreboard monitor: every done pulse pops one expectation
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_done: got d=%b with no pending operation at %0t", d, $time);
                end else begin
                    check("scoreboard_d", d, exp_q.pop_front());
                end
            end
        end
    end

    // Issue one operation at the 6-cycle period; returns just after edge 5
    task automatic run_op(input logic [3:0] aa, input logic [3:0] bb, input logic [4:0] e);
        a = aa;
        b = bb;
        start = 1'b1;
        exp_q.push_back(e);
        tick();
        start = 1'b0;
        a = ~aa;
        b = 4'($urandom);
        repeat (5) tick();
    endtask

    vec_t vecs[8];

    initial begin
        int n0;
        int starts;
        vecs[0] = '{4'd9,  4'd3,  5'b00110};
        vecs[1] = '{4'd3,  4'd5,  5'b11110};
        vecs[2] = '{4'd0,  4'd15, 5'b10001};
        vecs[3] = '{4'd7,  4'd7,  5'b00000};
        vecs[4] = '{4'd15, 4'd0,  5'b01111};
        vecs[5] = '{4'd8,  4'd9,  5'b11111};
        vecs[6] = '{4'd15, 4'd15, 5'b00000};
        vecs[7] = '{4'd10, 4'd4,  5'b00110};

        rst = 1'b1;
        start = 1'b0;
        a = 4'd0;
        b = 4'd0;
        tick();
        tick();
        check("reset_busy", {4'd0, busy}, 5'd0);
        check("reset_done", {4'd0, done}, 5'd0);
        check("reset_d", d, 5'd0);
        rst = 1'b0;
        tick();

        // Basic subtract with cycle-accurate handshake
        a = 4'd9;
        b = 4'd3;
        start = 1'b1;
        exp_q.push_back(5'b00110);
        tick();
        start = 1'b0;
        a = 4'd0;
        b = 4'd15;
        check("c0_busy", {4'd0, busy}, 5'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("c%0d_busy", k), {4'd0, busy}, 5'd1);
            check($sformatf("c%0d_done", k), {4'd0, done}, 5'd0);
        end
        tick();
        check("c5_done", {4'd0, done}, 5'd1);
        check("c5_busy", {4'd0, busy}, 5'd0);
        check("c5_d", d, 5'b00110);
        tick();
        check("c6_done", {4'd0, done}, 5'd0);
        check("c6_busy", {4'd0, busy}, 5'd0);
        check("c6_d_hold", d, 5'b00110);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].va, vecs[i].vb, sat(vecs[i].vexp));
            check($sformatf("vec%0d_d", i), d, sat(vecs[i].vexp));
        end
        tick();

        // Start during busy is ignored
        n0 = done_cnt;
        a = 4'd12;
        b = 4'd4;
        start = 1'b1;
        exp_q.push_back(5'b01000);
        tick();
        start = 1'b0;
        tick();
        a = 4'd1;
        b = 4'd2;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        repeat (14) tick();
        check("busy_start_done_count", 5'(done_cnt - n0), 5'd1);
        check("busy_start_d", d, 5'b01000);

        // Reset mid-operation discards the partial result
        a = 4'd10;
        b = 4'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", {4'd0, busy}, 5'd0);
        check("midrst_done", {4'd0, done}, 5'd0);
        check("midrst_d", d, 5'd0);
        n0 = done_cnt;
        repeat (5) tick();
        check("midrst_no_done", 5'(done_cnt - n0), 5'd0);

        // Exhaustive sweep at the minimum period
        n0 = done_cnt;
        starts = 0;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                run_op(4'(ia), 4'(ib), model(4'(ia), 4'(ib)));
                starts++;
            end
        end
        repeat (3) tick();
        compared++;
        if (done_cnt - n0 != starts) begin
            mismatched++;
            $display("FAIL exhaustive_done_count: got %0d expected %0d", done_cnt - n0, starts);
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL pending_results: got %0d left expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
